// File: rtl/uart_fifo_pkg.sv
// Shared mode constants and width helpers for the parametrised UART FIFO.
package uart_fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Smallest n with 2**n >= value; 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int addr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_sync_fifo_param_if.sv
// FIFO user-side bundle: write/read handshakes, status, threshold and error flags.
interface uart_sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
);
    import uart_fifo_pkg::*;

    localparam int CNT_W = cnt_width(DEPTH);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] level;
    logic             geq_level;
    logic             clr_err;
    logic             overflow;
    logic             underflow;

    modport slave (
        input  flush, wr_en, wr_data, rd_en, level, clr_err,
        output rd_data, rd_valid, full, empty, count, geq_level, overflow, underflow
    );

    modport master (
        output flush, wr_en, wr_data, rd_en, level, clr_err,
        input  rd_data, rd_valid, full, empty, count, geq_level, overflow, underflow
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port FIFO storage: synchronous write, registered or asynchronous read.
module uart_fifo_mem
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 256,
    parameter int FWFT   = FIFO_MODE_REG,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    // Array deliberately left without reset so it can map onto block RAM.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_async_rd
            logic unused_rd_ctrl;
            assign unused_rd_ctrl = &{1'b0, rd_en_i, reset_n};
            assign rd_data_o      = mem_q[rd_addr_i];
        end else begin : g_sync_rd
            logic [WIDTH-1:0] rd_data_q;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    rd_data_q <= '0;
                end else if (rd_en_i) begin
                    rd_data_q <= mem_q[rd_addr_i];
                end
            end
            assign rd_data_o = rd_data_q;
        end
    endgenerate

endmodule

// File: rtl/uart_sync_fifo_param.sv
// Parametrised single-clock UART FIFO: pointers, occupancy, threshold, sticky errors, flush.
module uart_sync_fifo_param
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int FWFT  = FIFO_MODE_REG
) (
    input logic                   clock,
    input logic                   reset_n,
    uart_sync_fifo_param_if.slave bus
);

    localparam int ADDR_W = addr_width(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    // Explicit wrap keeps non-power-of-two depths inside the array.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + ADDR_W'(1);
    endfunction

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full, empty;
    logic              rd_acc, wr_acc;
    logic [WIDTH-1:0]  rd_data;

    assign empty  = (count_q == '0);
    assign full   = (count_q == DEPTH_CNT);
    assign rd_acc = ~bus.flush & bus.rd_en & ~empty;
    assign wr_acc = ~bus.flush & bus.wr_en & (~full | rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CNT_W'(1);
            end
            rd_valid_d = rd_acc;
        end

        // Clear first so a same-cycle error still leaves the flag set.
        if (bus.clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (!bus.flush && bus.wr_en && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (!bus.flush && bus.rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    uart_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .FWFT   (FWFT),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.wr_data),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    assign bus.rd_data   = rd_data;
    assign bus.rd_valid  = (FWFT == FIFO_MODE_FWFT) ? ~empty : rd_valid_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;
    assign bus.geq_level = (count_q >= bus.level);
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_uart_sync_fifo_param.sv
// Directed bench for uart_sync_fifo_param: 256x8 registered, 5x12 wrap, 4x8 FWFT instances.
module tb_uart_sync_fifo_param;
    import uart_fifo_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    uart_sync_fifo_param_if #(.WIDTH(8),  .DEPTH(256)) bus_a ();
    uart_sync_fifo_param_if #(.WIDTH(12), .DEPTH(5))   bus_b ();
    uart_sync_fifo_param_if #(.WIDTH(8),  .DEPTH(4))   bus_c ();

    uart_sync_fifo_param #(.WIDTH(8),  .DEPTH(256), .FWFT(FIFO_MODE_REG))  u_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));
    uart_sync_fifo_param #(.WIDTH(12), .DEPTH(5),   .FWFT(FIFO_MODE_REG))  u_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));
    uart_sync_fifo_param #(.WIDTH(8),  .DEPTH(4),   .FWFT(FIFO_MODE_FWFT)) u_c (.clock(clock), .reset_n(reset_n), .bus(bus_c));

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic init_inputs();
        bus_a.flush = 0; bus_a.wr_en = 0; bus_a.wr_data = '0; bus_a.rd_en = 0; bus_a.level = '0; bus_a.clr_err = 0;
        bus_b.flush = 0; bus_b.wr_en = 0; bus_b.wr_data = '0; bus_b.rd_en = 0; bus_b.level = '0; bus_b.clr_err = 0;
        bus_c.flush = 0; bus_c.wr_en = 0; bus_c.wr_data = '0; bus_c.rd_en = 0; bus_c.level = '0; bus_c.clr_err = 0;
    endtask

    task automatic fill_a(input logic [7:0] key);
        for (int i = 0; i < 256; i++) begin
            bus_a.wr_en   = 1'b1;
            bus_a.wr_data = 8'(i) ^ key;
            tick();
        end
        bus_a.wr_en = 1'b0;
    endtask

    task automatic clear_err_a();
        bus_a.clr_err = 1'b1;
        tick();
        bus_a.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        n_checks++;
        if (bus_a.empty !== 1'b1 || bus_a.full !== 1'b0 || bus_a.count !== 9'd0)
            $display("FAIL reset_status: empty=%b full=%b count=%0d, required 1 0 0", bus_a.empty, bus_a.full, bus_a.count);
        else n_pass++;
        n_checks++;
        if (bus_a.rd_data !== 8'h00 || bus_a.rd_valid !== 1'b0)
            $display("FAIL reset_read: rd_data=%h rd_valid=%b, required 00 0", bus_a.rd_data, bus_a.rd_valid);
        else n_pass++;
        n_checks++;
        if (bus_a.overflow !== 1'b0 || bus_a.underflow !== 1'b0)
            $display("FAIL reset_flags: ovf=%b udf=%b, required 0 0", bus_a.overflow, bus_a.underflow);
        else n_pass++;
        n_checks++;
        if (bus_a.geq_level !== 1'b1)
            $display("FAIL level_zero: geq_level=%b, required 1", bus_a.geq_level);
        else n_pass++;
        n_checks++;
        if (bus_c.rd_valid !== 1'b0 || bus_c.empty !== 1'b1)
            $display("FAIL reset_fwft: rd_valid=%b empty=%b, required 0 1", bus_c.rd_valid, bus_c.empty);
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        bus_a.level = 9'd64;
        for (int i = 0; i < 256; i++) begin
            bus_a.wr_en   = 1'b1;
            bus_a.wr_data = 8'(i);
            tick();
            n_checks++;
            if (bus_a.geq_level !== (i + 1 >= 64))
                $display("FAIL geq_level after write %0d: got %b, required %b", i + 1, bus_a.geq_level, (i + 1 >= 64));
            else n_pass++;
        end
        bus_a.wr_en = 1'b0;
        n_checks++;
        if (bus_a.full !== 1'b1 || bus_a.count !== 9'd256)
            $display("FAIL fill_full: full=%b count=%0d, required 1 256", bus_a.full, bus_a.count);
        else n_pass++;
        bus_a.level = 9'd257;
        #1;
        n_checks++;
        if (bus_a.geq_level !== 1'b0)
            $display("FAIL level_above_depth: geq_level=%b, required 0", bus_a.geq_level);
        else n_pass++;
        bus_a.level = 9'd64;
        bus_a.rd_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            n_checks++;
            if (bus_a.rd_data !== 8'(i) || bus_a.rd_valid !== 1'b1)
                $display("FAIL drain_data %0d: rd_data=%h rd_valid=%b, required %h 1", i, bus_a.rd_data, bus_a.rd_valid, 8'(i));
            else n_pass++;
        end
        bus_a.rd_en = 1'b0;
        tick();
        n_checks++;
        if (bus_a.empty !== 1'b1 || bus_a.rd_valid !== 1'b0 || bus_a.rd_data !== 8'hFF)
            $display("FAIL drain_end: empty=%b rd_valid=%b rd_data=%h, required 1 0 ff", bus_a.empty, bus_a.rd_valid, bus_a.rd_data);
        else n_pass++;
        n_checks++;
        if (bus_a.overflow !== 1'b0 || bus_a.underflow !== 1'b0)
            $display("FAIL drain_flags: ovf=%b udf=%b, required 0 0", bus_a.overflow, bus_a.underflow);
        else n_pass++;
    endtask

    task automatic test_overflow_underflow();
        fill_a(8'h5A);
        bus_a.wr_en   = 1'b1;
        bus_a.wr_data = 8'hEE;
        tick();
        bus_a.wr_en = 1'b0;
        n_checks++;
        if (bus_a.count !== 9'd256 || bus_a.overflow !== 1'b1 || bus_a.underflow !== 1'b0)
            $display("FAIL overflow_set: count=%0d ovf=%b udf=%b, required 256 1 0", bus_a.count, bus_a.overflow, bus_a.underflow);
        else n_pass++;
        bus_a.rd_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            n_checks++;
            if (bus_a.rd_data !== (8'(i) ^ 8'h5A))
                $display("FAIL overflow_contents %0d: rd_data=%h, required %h", i, bus_a.rd_data, 8'(i) ^ 8'h5A);
            else n_pass++;
        end
        bus_a.rd_en = 1'b0;
        tick();
        bus_a.rd_en = 1'b1;
        tick();
        bus_a.rd_en = 1'b0;
        n_checks++;
        if (bus_a.underflow !== 1'b1 || bus_a.rd_valid !== 1'b0 || bus_a.empty !== 1'b1)
            $display("FAIL underflow_set: udf=%b rd_valid=%b empty=%b, required 1 0 1", bus_a.underflow, bus_a.rd_valid, bus_a.empty);
        else n_pass++;
        clear_err_a();
        n_checks++;
        if (bus_a.overflow !== 1'b0 || bus_a.underflow !== 1'b0)
            $display("FAIL clr_err: ovf=%b udf=%b, required 0 0", bus_a.overflow, bus_a.underflow);
        else n_pass++;
        bus_a.rd_en   = 1'b1;
        bus_a.clr_err = 1'b1;
        tick();
        bus_a.rd_en   = 1'b0;
        bus_a.clr_err = 1'b0;
        n_checks++;
        if (bus_a.underflow !== 1'b1 || bus_a.overflow !== 1'b0)
            $display("FAIL set_beats_clear: udf=%b ovf=%b, required 1 0", bus_a.underflow, bus_a.overflow);
        else n_pass++;
        clear_err_a();
    endtask

    task automatic test_back_to_back();
        logic [7:0] model [$];
        logic [7:0] exp;
        logic [7:0] wd;
        fill_a(8'h00);
        for (int i = 0; i < 256; i++) model.push_back(8'(i));
        bus_a.rd_en = 1'b1;
        bus_a.wr_en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            wd = 8'(c * 7 + 3);
            bus_a.wr_data = wd;
            tick();
            exp = model.pop_front();
            model.push_back(wd);
            n_checks++;
            if (bus_a.rd_data !== exp || bus_a.count !== 9'd256 || bus_a.rd_valid !== 1'b1)
                $display("FAIL rw_full cycle %0d: rd_data=%h count=%0d rd_valid=%b, required %h 256 1", c, bus_a.rd_data, bus_a.count, bus_a.rd_valid, exp);
            else n_pass++;
        end
        bus_a.wr_en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tick();
            exp = model.pop_front();
            n_checks++;
            if (bus_a.rd_data !== exp)
                $display("FAIL rw_full_drain %0d: rd_data=%h, required %h", i, bus_a.rd_data, exp);
            else n_pass++;
        end
        bus_a.rd_en = 1'b0;
        tick();
        n_checks++;
        if (bus_a.empty !== 1'b1 || bus_a.overflow !== 1'b0 || bus_a.underflow !== 1'b0)
            $display("FAIL rw_full_end: empty=%b ovf=%b udf=%b, required 1 0 0", bus_a.empty, bus_a.overflow, bus_a.underflow);
        else n_pass++;
    endtask

    task automatic test_rw_empty();
        bus_a.wr_en   = 1'b1;
        bus_a.rd_en   = 1'b1;
        bus_a.wr_data = 8'h3C;
        tick();
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b0;
        n_checks++;
        if (bus_a.count !== 9'd1 || bus_a.underflow !== 1'b1 || bus_a.rd_valid !== 1'b0 || bus_a.overflow !== 1'b0)
            $display("FAIL rw_empty: count=%0d udf=%b rd_valid=%b ovf=%b, required 1 1 0 0", bus_a.count, bus_a.underflow, bus_a.rd_valid, bus_a.overflow);
        else n_pass++;
        bus_a.rd_en = 1'b1;
        tick();
        bus_a.rd_en = 1'b0;
        n_checks++;
        if (bus_a.rd_data !== 8'h3C || bus_a.rd_valid !== 1'b1)
            $display("FAIL rw_empty_read: rd_data=%h rd_valid=%b, required 3c 1", bus_a.rd_data, bus_a.rd_valid);
        else n_pass++;
        clear_err_a();
    endtask

    task automatic test_flush();
        bus_a.rd_en = 1'b1;
        tick();
        bus_a.rd_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus_a.wr_en   = 1'b1;
            bus_a.wr_data = 8'(8'h40 + i);
            tick();
        end
        bus_a.wr_en = 1'b0;
        n_checks++;
        if (bus_a.count !== 9'd10)
            $display("FAIL flush_pre: count=%0d, required 10", bus_a.count);
        else n_pass++;
        bus_a.flush   = 1'b1;
        bus_a.wr_en   = 1'b1;
        bus_a.wr_data = 8'h99;
        bus_a.rd_en   = 1'b1;
        tick();
        bus_a.flush = 1'b0;
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b0;
        n_checks++;
        if (bus_a.count !== 9'd0 || bus_a.empty !== 1'b1 || bus_a.rd_valid !== 1'b0 || bus_a.rd_data !== 8'h3C)
            $display("FAIL flush_state: count=%0d empty=%b rd_valid=%b rd_data=%h, required 0 1 0 3c", bus_a.count, bus_a.empty, bus_a.rd_valid, bus_a.rd_data);
        else n_pass++;
        n_checks++;
        if (bus_a.underflow !== 1'b1 || bus_a.overflow !== 1'b0)
            $display("FAIL flush_flags: udf=%b ovf=%b, required 1 0", bus_a.underflow, bus_a.overflow);
        else n_pass++;
        bus_a.wr_en   = 1'b1;
        bus_a.wr_data = 8'h11;
        tick();
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b1;
        tick();
        bus_a.rd_en = 1'b0;
        n_checks++;
        if (bus_a.rd_data !== 8'h11 || bus_a.empty !== 1'b1)
            $display("FAIL flush_discard: rd_data=%h empty=%b, required 11 1", bus_a.rd_data, bus_a.empty);
        else n_pass++;
        clear_err_a();
    endtask

    task automatic test_wrap();
        logic [11:0] model [$];
        logic [11:0] wd;
        logic [11:0] exp;
        int wptr = 0;
        int rptr = 0;
        int k    = 0;
        int n;
        int m;
        for (int r = 0; r < 23; r++) begin
            n = int'($urandom_range(1, 3));
            if (n > 5 - model.size()) n = 5 - model.size();
            for (int j = 0; j < n; j++) begin
                wd = 12'(k * 37 + 5);
                k++;
                bus_b.wr_en   = 1'b1;
                bus_b.wr_data = wd;
                model.push_back(wd);
                wptr = (wptr + 1) % 5;
                tick();
                n_checks++;
                if (bus_b.count !== 3'(model.size()) || u_b.wr_ptr_q !== 3'(wptr) || bus_b.full !== (model.size() == 5))
                    $display("FAIL wrap_write round %0d: count=%0d wr_ptr=%0d full=%b, required %0d %0d %b", r, bus_b.count, u_b.wr_ptr_q, bus_b.full, model.size(), wptr, (model.size() == 5));
                else n_pass++;
            end
            bus_b.wr_en = 1'b0;
            m = int'($urandom_range(1, 3));
            if (m > model.size()) m = model.size();
            for (int j = 0; j < m; j++) begin
                bus_b.rd_en = 1'b1;
                tick();
                exp  = model.pop_front();
                rptr = (rptr + 1) % 5;
                n_checks++;
                if (bus_b.rd_data !== exp || bus_b.rd_valid !== 1'b1 || bus_b.count !== 3'(model.size()) || u_b.rd_ptr_q !== 3'(rptr))
                    $display("FAIL wrap_read round %0d: rd_data=%h count=%0d rd_ptr=%0d, required %h %0d %0d", r, bus_b.rd_data, bus_b.count, u_b.rd_ptr_q, exp, model.size(), rptr);
                else n_pass++;
            end
            bus_b.rd_en = 1'b0;
        end
        n_checks++;
        if (bus_b.overflow !== 1'b0 || bus_b.underflow !== 1'b0)
            $display("FAIL wrap_flags: ovf=%b udf=%b, required 0 0", bus_b.overflow, bus_b.underflow);
        else n_pass++;
    endtask

    task automatic test_fwft();
        bus_c.wr_en   = 1'b1;
        bus_c.wr_data = 8'hA5;
        tick();
        bus_c.wr_en = 1'b0;
        n_checks++;
        if (bus_c.rd_valid !== 1'b1 || bus_c.rd_data !== 8'hA5 || bus_c.count !== 3'd1)
            $display("FAIL fwft_show: rd_valid=%b rd_data=%h count=%0d, required 1 a5 1", bus_c.rd_valid, bus_c.rd_data, bus_c.count);
        else n_pass++;
        tick();
        n_checks++;
        if (bus_c.rd_valid !== 1'b1 || bus_c.rd_data !== 8'hA5)
            $display("FAIL fwft_hold: rd_valid=%b rd_data=%h, required 1 a5", bus_c.rd_valid, bus_c.rd_data);
        else n_pass++;
        bus_c.rd_en = 1'b1;
        tick();
        bus_c.rd_en = 1'b0;
        n_checks++;
        if (bus_c.empty !== 1'b1 || bus_c.rd_valid !== 1'b0)
            $display("FAIL fwft_pop: empty=%b rd_valid=%b, required 1 0", bus_c.empty, bus_c.rd_valid);
        else n_pass++;
        bus_c.wr_en   = 1'b1;
        bus_c.wr_data = 8'h11;
        tick();
        bus_c.wr_data = 8'h22;
        tick();
        bus_c.wr_en = 1'b0;
        n_checks++;
        if (bus_c.rd_data !== 8'h11 || bus_c.count !== 3'd2)
            $display("FAIL fwft_first: rd_data=%h count=%0d, required 11 2", bus_c.rd_data, bus_c.count);
        else n_pass++;
        bus_c.rd_en = 1'b1;
        tick();
        bus_c.rd_en = 1'b0;
        n_checks++;
        if (bus_c.rd_data !== 8'h22 || bus_c.rd_valid !== 1'b1 || bus_c.count !== 3'd1)
            $display("FAIL fwft_second: rd_data=%h rd_valid=%b count=%0d, required 22 1 1", bus_c.rd_data, bus_c.rd_valid, bus_c.count);
        else n_pass++;
        bus_c.rd_en = 1'b1;
        tick();
        bus_c.rd_en = 1'b0;
        n_checks++;
        if (bus_c.empty !== 1'b1 || bus_c.underflow !== 1'b0)
            $display("FAIL fwft_drained: empty=%b udf=%b, required 1 0", bus_c.empty, bus_c.underflow);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bus_a.rd_en = 1'b1;
        tick();
        bus_a.rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_a.wr_en   = 1'b1;
            bus_a.wr_data = 8'(8'hC0 + i);
            tick();
        end
        bus_a.wr_data = 8'hD0;
        bus_a.rd_en   = 1'b1;
        tick();
        n_checks++;
        if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 8'hC0 || bus_a.count !== 9'd5 || bus_a.underflow !== 1'b1)
            $display("FAIL pre_reset: rd_valid=%b rd_data=%h count=%0d udf=%b, required 1 c0 5 1", bus_a.rd_valid, bus_a.rd_data, bus_a.count, bus_a.underflow);
        else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus_a.count !== 9'd0 || bus_a.empty !== 1'b1 || bus_a.full !== 1'b0 || bus_a.rd_valid !== 1'b0 || bus_a.rd_data !== 8'h00)
            $display("FAIL async_reset: count=%0d empty=%b full=%b rd_valid=%b rd_data=%h, required 0 1 0 0 00", bus_a.count, bus_a.empty, bus_a.full, bus_a.rd_valid, bus_a.rd_data);
        else n_pass++;
        n_checks++;
        if (bus_a.overflow !== 1'b0 || bus_a.underflow !== 1'b0)
            $display("FAIL async_reset_flags: ovf=%b udf=%b, required 0 0", bus_a.overflow, bus_a.underflow);
        else n_pass++;
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (bus_a.empty !== 1'b1 || bus_a.count !== 9'd0)
            $display("FAIL post_reset: empty=%b count=%0d, required 1 0", bus_a.empty, bus_a.count);
        else n_pass++;
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_back_to_back();
        test_rw_empty();
        test_flush();
        test_wrap();
        test_fwft();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
